// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Brief    : FSM encoding, line levels and frame-length helper for serial_tx_frame.
// Revision : 1.0
// ============================================================================
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int data_w,
                                      input int clks_per_bit,
                                      input int stop_bits,
                                      input int parity_bits);
    return clks_per_bit * (1 + data_w + parity_bits + stop_bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_timer
// Brief    : Down-counter giving a one-cycle bit_tick_o every CLKS_PER_BIT cycles.
// Revision : 1.0
// ============================================================================
module bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic reload_i,
  output logic bit_tick_o
);

  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload beats clear so a state entry out of IDLE starts a full bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = C_RELOAD;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = C_RELOAD;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = !clear_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/serial_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_frame
// Brief    : Parallel-to-serial frame transmitter (start, data LSB first,
//            optional parity, stop). Define SERIAL_TX_PARITY_EN for parity.
// Revision : 1.0
// ============================================================================
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              txd,
  output logic              done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] C_LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] C_LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              txd_q;
  logic              txd_d;
  logic              done_q;
  logic              done_d;
  logic              accept;
  logic              bit_tick;
  logic              timer_clear;
  logic              timer_reload;

  assign accept       = (state_q == IDLE) && send;
  assign timer_clear  = (state_q == IDLE);
  assign timer_reload = (state_d != state_q) && (state_d != IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear),
    .reload_i   (timer_reload),
    .bit_tick_o (bit_tick)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity is frozen with the word so later data changes cannot leak in.
  assign parity_d = accept ? ((^data) ^ (PARITY_ODD != 0)) : parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bit-count logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == C_LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == C_LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = data;
    end else if ((state_q == DATA) && bit_tick) begin
      shift_d = shift_q >> 1;
    end
  end

  // Outputs: txd is precomputed from the next state so the line comes from a flop.
  always_comb begin
    ready  = (state_q == IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    txd_d  = IDLE_LEVEL;
    case (state_d)
      START:   txd_d = START_LEVEL;
      DATA:    txd_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

  assign txd  = txd_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_frame
// Brief    : Scoreboard bench for serial_tx_frame (default and 5-bit/2-stop builds).
// Revision : 1.0
// ============================================================================
module tb_serial_tx_frame;

  localparam int A_W = 8;
  localparam int A_CPB = 4;
  localparam int A_STOP = 1;
  localparam int A_ODD = 0;
  localparam int B_W = 5;
  localparam int B_CPB = 3;
  localparam int B_STOP = 2;
  localparam int B_ODD = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F_A = A_CPB * (1 + A_W + P + A_STOP);
  localparam int F_B = B_CPB * (1 + B_W + P + B_STOP);
  localparam int WAIT_MAX = 500;

  typedef struct {
    logic [15:0] word;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b1;
  int   cyc = 0;

  logic           send_a = 1'b0;
  logic [A_W-1:0] data_a = '0;
  logic           ready_a, txd_a, done_a;
  logic           send_b = 1'b0;
  logic [B_W-1:0] data_b = '0;
  logic           ready_b, txd_b, done_b;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   busy[2];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  serial_tx_frame #(
    .DATA_W(A_W), .CLKS_PER_BIT(A_CPB), .STOP_BITS(A_STOP), .PARITY_ODD(A_ODD)
  ) u_dut_a (
    .clk(clk), .rst(rst), .send(send_a), .data(data_a),
    .ready(ready_a), .txd(txd_a), .done(done_a)
  );

  serial_tx_frame #(
    .DATA_W(B_W), .CLKS_PER_BIT(B_CPB), .STOP_BITS(B_STOP), .PARITY_ODD(B_ODD)
  ) u_dut_b (
    .clk(clk), .rst(rst), .send(send_b), .data(data_b),
    .ready(ready_b), .txd(txd_b), .done(done_b)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int get_txd(input int sel);
    return (sel != 0) ? int'(txd_b) : int'(txd_a);
  endfunction
  function automatic int get_ready(input int sel);
    return (sel != 0) ? int'(ready_b) : int'(ready_a);
  endfunction
  function automatic int get_done(input int sel);
    return (sel != 0) ? int'(done_b) : int'(done_a);
  endfunction
  function automatic int qsize(input int sel);
    return (sel != 0) ? q_b.size() : q_a.size();
  endfunction
  function automatic string pfx(input int sel);
    return (sel != 0) ? "B." : "A.";
  endfunction

  // Expected line level for frame cycle c of a given word.
  function automatic int exp_bit(input int c, input int sel, input logic [15:0] word);
    int w, cpb, odd, slot;
    logic [15:0] mask;
    w    = (sel != 0) ? B_W : A_W;
    cpb  = (sel != 0) ? B_CPB : A_CPB;
    odd  = (sel != 0) ? B_ODD : A_ODD;
    mask = 16'((32'd1 << w) - 1);
    slot = c / cpb;
    if (slot == 0) return 0;
    if (slot <= w) return int'(word[slot-1]);
    if ((P == 1) && (slot == w + 1)) return int'(^(word & mask)) ^ odd;
    return 1;
  endfunction

  task automatic monitor(input int sel);
    int   f;
    exp_t e;
    bit   aborted;
    bit   just_done;
    f = (sel != 0) ? F_B : F_A;
    just_done = 1'b0;
    forever begin
      @(negedge clk);
      if (just_done && !rst_d) check({pfx(sel), "done_clear"}, get_done(sel), 0);
      just_done = 1'b0;
      if (!rst_d && get_txd(sel) == 0) begin
        busy[sel] = 1'b1;
        check({pfx(sel), "frame_expected"}, int'(qsize(sel) > 0), 1);
        if (qsize(sel) > 0) begin
          e = (sel != 0) ? q_b.pop_front() : q_a.pop_front();
        end else begin
          e.word = 16'h0;
          e.acc  = cyc - 1;
        end
        check({pfx(sel), "start_lat"}, cyc - e.acc, 1);
        aborted = 1'b0;
        for (int c = 0; c < f; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_d) begin
            aborted = 1'b1;
            break;
          end
          check({pfx(sel), "txd"}, get_txd(sel), exp_bit(c, sel, e.word));
          check({pfx(sel), "ready_busy"}, get_ready(sel), 0);
          check({pfx(sel), "done_busy"}, get_done(sel), 0);
        end
        if (!aborted) begin
          @(negedge clk);
          if (!rst_d) begin
            check({pfx(sel), "done_pulse"}, get_done(sel), 1);
            check({pfx(sel), "ready_back"}, get_ready(sel), 1);
            check({pfx(sel), "txd_idle"}, get_txd(sel), 1);
            just_done = 1'b1;
          end
        end
        busy[sel] = 1'b0;
      end
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [15:0] w);
    if (sel != 0) begin
      send_b = s;
      data_b = w[B_W-1:0];
    end else begin
      send_a = s;
      data_a = w[A_W-1:0];
    end
  endtask

  // Called at a negedge; the word is accepted in the first cycle with ready high.
  task automatic send_word(input int sel, input logic [15:0] w, input bit hold, output int acc);
    int   g;
    exp_t e;
    g = 0;
    drive(sel, 1'b1, w);
    while (get_ready(sel) == 0 && g < WAIT_MAX) begin
      @(negedge clk);
      g++;
    end
    check({pfx(sel), "accept"}, get_ready(sel), 1);
    acc    = cyc;
    e.word = w;
    e.acc  = cyc;
    if (sel != 0) q_b.push_back(e);
    else q_a.push_back(e);
    @(negedge clk);
    if (!hold) begin
      if (sel != 0) send_b = 1'b0;
      else send_a = 1'b0;
    end
  endtask

  task automatic wait_idle(input int sel);
    int g;
    g = 0;
    while ((qsize(sel) != 0 || busy[sel] || get_ready(sel) == 0) && g < WAIT_MAX) begin
      @(negedge clk);
      g++;
    end
    check({pfx(sel), "idle_reached"}, int'(g < WAIT_MAX), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc1, acc2, cnt;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(negedge clk);
    check("A.rst_txd", int'(txd_a), 1);
    check("A.rst_ready", int'(ready_a), 1);
    check("A.rst_done", int'(done_a), 0);
    check("B.rst_txd", int'(txd_b), 1);
    check("B.rst_ready", int'(ready_b), 1);
    check("B.rst_done", int'(done_b), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_word(0, 16'hA5, 1'b0, acc1);
    wait_idle(0);

    // Pulse on send mid-frame must be ignored; data change must not leak in.
    send_word(0, 16'h3C, 1'b0, acc1);
    repeat (5) @(negedge clk);
    drive(0, 1'b1, 16'h55);
    check("A.ignored_busy", int'(ready_a), 0);
    @(negedge clk);
    send_a = 1'b0;
    wait_idle(0);

    send_word(1, 16'h1F, 1'b0, acc1);
    repeat (6) @(negedge clk);
    data_b = '0;
    wait_idle(1);
    send_word(1, 16'h0A, 1'b0, acc1);
    wait_idle(1);

    // Back-to-back with send held high.
    send_word(0, 16'h00, 1'b1, acc1);
    send_word(0, 16'hFF, 1'b0, acc2);
    check("A.b2b_gap", acc2 - acc1, F_A + 1);
    wait_idle(0);
    send_word(1, 16'h15, 1'b1, acc1);
    send_word(1, 16'h0A, 1'b0, acc2);
    check("B.b2b_gap", acc2 - acc1, F_B + 1);
    wait_idle(1);

    // Abort during the third data bit.
    send_word(0, 16'hA5, 1'b0, acc1);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("A.abort_txd", int'(txd_a), 1);
    check("A.abort_ready", int'(ready_a), 1);
    check("A.abort_done", int'(done_a), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      cnt += int'(done_a);
    end
    check("A.no_done_after_abort", cnt, 0);
    send_word(0, 16'h3C, 1'b0, acc1);
    wait_idle(0);

    // Reset and send together: reset wins.
    drive(0, 1'b1, 16'h81);
    rst = 1'b1;
    @(negedge clk);
    check("A.rst_send_ready", int'(ready_a), 1);
    check("A.rst_send_txd", int'(txd_a), 1);
    rst = 1'b0;
    send_a = 1'b0;
    repeat (3) @(negedge clk);
    check("A.rst_send_no_frame", int'(txd_a), 1);

    for (int i = 0; i < 3; i++) begin
      send_word(0, 16'($urandom_range(0, 255)), 1'b0, acc1);
      wait_idle(0);
      send_word(1, 16'($urandom_range(0, 31)), 1'b0, acc1);
      wait_idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
